// File: rtl/adder_32_bit.sv
// Registered binary adder built from 4-bit carry-lookahead groups with a
// second-level lookahead unit. Optional signed overflow output: ADDER_OVERFLOW_FLAG_EN.
module adder_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
`ifdef ADDER_OVERFLOW_FLAG_EN
  output logic             overflow,
`endif
  output logic             carry_out
);

  localparam int NG = WIDTH / 4;

  if (WIDTH % 4 != 0) begin : g_width_check
    $error("adder_32_bit: WIDTH must be a multiple of 4");
  end

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate for each 4-bit slice.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < NG; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
  end

  // Second-level lookahead: each group carry is a flat sum of products over
  // all lower groups and carry_in, not a ripple through grp_c.
  always_comb begin
    logic acc;
    logic prod;
    grp_c    = '0;
    grp_c[0] = carry_in;
    for (int j = 0; j < NG; j++) begin
      acc  = grp_g[j];
      prod = grp_p[j];
      for (int i = j - 1; i >= 0; i--) begin
        acc  = acc | (prod & grp_g[i]);
        prod = prod & grp_p[i];
      end
      grp_c[j+1] = acc | (prod & carry_in);
    end
  end

  // Per-bit carries inside each group, expanded from that group's carry-in.
  always_comb begin
    logic acc;
    logic prod;
    c = '0;
    for (int k = 0; k < NG; k++) begin
      c[4*k] = grp_c[k];
      for (int n = 1; n < 4; n++) begin
        acc  = g[4*k+n-1];
        prod = p[4*k+n-1];
        for (int i = n - 2; i >= 0; i--) begin
          acc  = acc | (prod & g[4*k+i]);
          prod = prod & p[4*k+i];
        end
        c[4*k+n] = acc | (prod & grp_c[k]);
      end
    end
    c[WIDTH] = grp_c[NG];
  end

  assign sum = p ^ c[WIDTH-1:0];

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      result    <= sum;
      carry_out <= c[WIDTH];
    end
  end

`ifdef ADDER_OVERFLOW_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= c[WIDTH] ^ c[WIDTH-1];
  end
`endif

endmodule

// File: tb/tb_adder_32_bit.sv
// Self-checking bench for adder_32_bit: directed vector table, reset cases,
// and back-to-back random operands against an arithmetic reference.
module tb_adder_32_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        carry_in;
  logic [31:0] result;
  logic        carry_out;
`ifdef ADDER_OVERFLOW_FLAG_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;

  adder_32_bit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .result    (result),
`ifdef ADDER_OVERFLOW_FLAG_EN
    .overflow  (overflow),
`endif
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_r;
    logic        exp_c;
    logic        exp_v;
  } vec_t;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: plain unsigned 33-bit addition; overflow from operand/result signs.
  task automatic ref_add(input logic [31:0] x, input logic [31:0] y, input logic ci,
                         output logic [31:0] r, output logic co, output logic v);
    logic [32:0] s;
    s  = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    r  = s[31:0];
    co = s[32];
    v  = (x[31] == y[31]) && (s[31] != x[31]);
  endtask

  task automatic check_outputs(input string name, input logic [31:0] er, input logic ec, input logic ev);
    check({name, ".result"}, {32'd0, result}, {32'd0, er});
    check({name, ".carry_out"}, {63'd0, carry_out}, {63'd0, ec});
`ifdef ADDER_OVERFLOW_FLAG_EN
    check({name, ".overflow"}, {63'd0, overflow}, {63'd0, ev});
`else
    if (ev === 1'bx) $display("unexpected X in overflow expectation for %s", name);
`endif
  endtask

  task automatic step(input logic r, input logic [31:0] x, input logic [31:0] y, input logic ci);
    rst = r; a = x; b = y; carry_in = ci;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] er;
    logic        ec;
    logic        ev;

    vecs.push_back('{32'h00000025, 32'h0000003F, 1'b0, 32'h00000064, 1'b0, 1'b0});
    vecs.push_back('{32'h00000098, 32'h0000003F, 1'b0, 32'h000000D7, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFF6, 32'hFFFFFFE9, 1'b0, 32'hFFFFFFDF, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFFF213, 32'h0000003F, 1'b0, 32'hFFFFF252, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFF213, 32'h00000000, 1'b0, 32'hFFFFF213, 1'b0, 1'b0});
    vecs.push_back('{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0});
    vecs.push_back('{32'h0FFFFFFF, 32'h00000000, 1'b1, 32'h10000000, 1'b0, 1'b0});

    // Reset with live operands: outputs cleared, operands discarded.
    @(negedge clk);
    step(1'b1, 32'h12345678, 32'h00000001, 1'b0);
    check_outputs("reset", 32'h0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_r, vecs[i].exp_c, vecs[i].exp_v);
    end

    // Reset mid-stream has priority over a carry-producing add.
    step(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check_outputs("pre_mid_reset", 32'hFFFFFFFF, 1'b1, 1'b0);
    step(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    check_outputs("mid_reset", 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h00000001, 32'h00000002, 1'b1);
    check_outputs("post_mid_reset", 32'h00000004, 1'b0, 1'b0);

    // Back-to-back random operands, one new set every cycle.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      logic        ci;
      x  = $urandom;
      y  = $urandom;
      ci = 1'($urandom_range(1, 0));
      if (i % 10 == 0) y = ~x;
      ref_add(x, y, ci, er, ec, ev);
      step(1'b0, x, y, ci);
      check_outputs($sformatf("rand%0d", i), er, ec, ev);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
